// File: rtl/csa_tree_pkg.sv
// Shared sizing helpers for the pipelined carry-save reduction tree.
package csa_tree_pkg;

    // Largest partial-product count the tree is sized for.
    localparam int MAX_PP = 32;

    // Row count entering level lvl (lvl = 0 is the raw partial-product set).
    // Each level turns every full triple into a sum/carry pair, so
    // n rows become n - floor(n/3).
    function automatic int csa_rows(int n, int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            r = r - r / 3;
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int csa_levels(int n);
        int r;
        int l;
        r = n;
        l = 0;
        for (int i = 0; i < MAX_PP; i++) begin
            if (r > 2) begin
                r = r - r / 3;
                l++;
            end
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_level.sv
// One combinational 3:2 carry-save reduction level.
// Row triples become a sum/carry pair; leftover rows pass straight through.
// Output row order: sum0, carry0, sum1, carry1, ..., then the leftovers.
// For a three-row input this means row 0 is the sum and row 1 the carry.
module csa_level
    import csa_tree_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ROWS_IN = 8
) (
    input  logic [ROWS_IN*WIDTH-1:0]                rows_i,
    output logic [csa_rows(ROWS_IN, 1)*WIDTH-1:0]   rows_o
);

    localparam int NUM_TRIPLES = ROWS_IN / 3;
    localparam int NUM_LEFT    = ROWS_IN - 3 * NUM_TRIPLES;

    for (genvar g = 0; g < NUM_TRIPLES; g++) begin : g_csa
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;

        assign a = rows_i[(3*g)*WIDTH   +: WIDTH];
        assign b = rows_i[(3*g+1)*WIDTH +: WIDTH];
        assign c = rows_i[(3*g+2)*WIDTH +: WIDTH];

        // Majority bit moves up one weight; the carry out of the top bit is dropped.
        assign rows_o[(2*g)*WIDTH   +: WIDTH] = a ^ b ^ c;
        assign rows_o[(2*g+1)*WIDTH +: WIDTH] = ((a & b) | (a & c) | (b & c)) << 1;
    end

    for (genvar j = 0; j < NUM_LEFT; j++) begin : g_pass
        assign rows_o[(2*NUM_TRIPLES+j)*WIDTH +: WIDTH] =
            rows_i[(3*NUM_TRIPLES+j)*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree: NUM_PP partial products -> sum/carry pair.
// One register rank per reduction level, global stall on output backpressure.
// Optional macro CSA_TREE_FINAL_ADD_EN adds a final rank that also produces
// product_out = sum_out + carry_out.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on the output side (adv = out_ready | ~out_valid),
// never on in_valid. While adv is low every rank holds, so sum_out/carry_out stay
// stable while out_valid is high and out_ready is low. Bubbles shift with the
// pipe and are never squeezed out.
module csa_tree_pipe
    import csa_tree_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_PP = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_PP*WIDTH-1:0] pp_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        sum_out,
    output logic [WIDTH-1:0]        carry_out
`ifdef CSA_TREE_FINAL_ADD_EN
    ,
    output logic [WIDTH-1:0]        product_out
`endif
);

    localparam int LEVELS = csa_levels(NUM_PP);

    logic adv;
    logic accept;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int RIN  = csa_rows(NUM_PP, l);
        localparam int ROUT = csa_rows(NUM_PP, l + 1);

        logic [RIN*WIDTH-1:0]  rows_in;
        logic                  valid_d;
        logic [ROUT*WIDTH-1:0] data_d;
        logic [ROUT*WIDTH-1:0] data_q;
        logic                  valid_q;

        if (l == 0) begin : g_first
            assign rows_in = pp_in;
            assign valid_d = accept;
        end else begin : g_next
            assign rows_in = g_lvl[l-1].data_q;
            assign valid_d = g_lvl[l-1].valid_q;
        end

        csa_level #(
            .WIDTH   (WIDTH),
            .ROWS_IN (RIN)
        ) u_level (
            .rows_i (rows_in),
            .rows_o (data_d)
        );

        // Pipeline rank after this level: load on advance, clear on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (adv) begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    logic [2*WIDTH-1:0] last_data;
    logic               last_valid;

    assign last_data  = g_lvl[LEVELS-1].data_q;
    assign last_valid = g_lvl[LEVELS-1].valid_q;

`ifdef CSA_TREE_FINAL_ADD_EN
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] prod_d;
    logic             fvalid_q;

    assign prod_d = last_data[WIDTH-1:0] + last_data[2*WIDTH-1:WIDTH];

    // Final rank: resolve the redundant pair and keep sum/carry aligned with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= '0;
            carry_q  <= '0;
            prod_q   <= '0;
            fvalid_q <= 1'b0;
        end else if (adv) begin
            sum_q    <= last_data[WIDTH-1:0];
            carry_q  <= last_data[2*WIDTH-1:WIDTH];
            prod_q   <= prod_d;
            fvalid_q <= last_valid;
        end
    end

    assign out_valid   = fvalid_q;
    assign sum_out     = sum_q;
    assign carry_out   = carry_q;
    assign product_out = prod_q;
`else
    assign out_valid = last_valid;
    assign sum_out   = last_data[WIDTH-1:0];
    assign carry_out = last_data[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: main NUM_PP=8 instance plus NUM_PP=3/9/13 instances.
module tb_csa_tree_pipe;

`ifdef CSA_TREE_FINAL_ADD_EN
    localparam int FA = 1;
`else
    localparam int FA = 0;
`endif

    logic clk;
    logic rst;
    logic in_valid_m;
    logic in_valid_s;
    logic out_ready_m;
    logic [13*16-1:0] pp_all;

    wire  [3:0]       ir;
    wire  [3:0]       ov;
    wire  [3:0]       iv;
    wire  [3:0]       ordy;
    wire  [3:0][15:0] so;
    wire  [3:0][15:0] co;
`ifdef CSA_TREE_FINAL_ADD_EN
    wire  [3:0][15:0] po;
`endif

    assign iv   = {in_valid_s, in_valid_s, in_valid_s, in_valid_m};
    assign ordy = {3'b111, out_ready_m};

    logic [15:0] exp_q [4][$];
    int          acc_q [4][$];

    int errors;
    int checks;
    int cyc;
    bit lat_chk;
    bit acc_main;
    bit bp_arm;
    int hold_left;
    logic [15:0] held_s;
    logic [15:0] held_c;

    csa_tree_pipe #(.WIDTH(16), .NUM_PP(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .pp_in(pp_all[8*16-1:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum_out(so[0]), .carry_out(co[0])
`ifdef CSA_TREE_FINAL_ADD_EN
        , .product_out(po[0])
`endif
    );

    csa_tree_pipe #(.WIDTH(16), .NUM_PP(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .pp_in(pp_all[3*16-1:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum_out(so[1]), .carry_out(co[1])
`ifdef CSA_TREE_FINAL_ADD_EN
        , .product_out(po[1])
`endif
    );

    csa_tree_pipe #(.WIDTH(16), .NUM_PP(9)) u_dut9 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .pp_in(pp_all[9*16-1:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum_out(so[2]), .carry_out(co[2])
`ifdef CSA_TREE_FINAL_ADD_EN
        , .product_out(po[2])
`endif
    );

    csa_tree_pipe #(.WIDTH(16), .NUM_PP(13)) u_dut13 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .pp_in(pp_all[13*16-1:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum_out(so[3]), .carry_out(co[3])
`ifdef CSA_TREE_FINAL_ADD_EN
        , .product_out(po[3])
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int npp(input int d);
        case (d)
            0:       return 8;
            1:       return 3;
            2:       return 9;
            default: return 13;
        endcase
    endfunction

    // Latencies: 8 -> 4 levels, 3 -> 1, 9 -> 4, 13 -> 5; one more with the final adder.
    function automatic int exp_lat(input int d);
        case (d)
            0:       return 4 + FA;
            1:       return 1 + FA;
            2:       return 4 + FA;
            default: return 5 + FA;
        endcase
    endfunction

    // Reference: plain modular sum of the first n partial products.
    function automatic logic [15:0] ref_sum(input int n);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            s = s + pp_all[i*16 +: 16];
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [15:0] e;
        int a;
        @(negedge clk);
        if (hold_left > 0) begin
            chk("hold_in_ready", 32'(ir[0]), 32'd0);
            chk("hold_sum", 32'(so[0]), 32'(held_s));
            chk("hold_carry", 32'(co[0]), 32'(held_c));
        end
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && ordy[d]) begin
                    chk($sformatf("pending_on_out_dut%0d", d), 32'(exp_q[d].size() > 0), 32'd1);
                    if (exp_q[d].size() > 0) begin
                        e = exp_q[d].pop_front();
                        a = acc_q[d].pop_front();
                        chk($sformatf("sum_carry_dut%0d", d), 32'(16'(so[d] + co[d])), 32'(e));
`ifdef CSA_TREE_FINAL_ADD_EN
                        chk($sformatf("product_dut%0d", d), 32'(po[d]), 32'(e));
`endif
                        if (lat_chk || d != 0) begin
                            chk($sformatf("latency_dut%0d", d), 32'(cyc - a), 32'(exp_lat(d)));
                        end
                    end
                end
                if (iv[d] && ir[d]) begin
                    exp_q[d].push_back(ref_sum(npp(d)));
                    acc_q[d].push_back(cyc);
                    if (d == 0) acc_main = 1'b1;
                end
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                exp_q[d].delete();
                acc_q[d].delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) out_ready_m = 1'b1;
        end else if (bp_arm && ov[0]) begin
            bp_arm      = 1'b0;
            hold_left   = 3;
            out_ready_m = 1'b0;
            held_s      = so[0];
            held_c      = co[0];
        end
    endtask

    // Driver: present the current pp_all to the main instance until accepted.
    task automatic send_main();
        acc_main   = 1'b0;
        in_valid_m = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc_main) break;
        end
        chk("accept_timeout", 32'(acc_main), 32'd1);
    endtask

    task automatic set_main(input logic [15:0] v);
        pp_all = '0;
        for (int i = 0; i < 8; i++) pp_all[i*16 +: 16] = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
            tick();
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("drain_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
        end
        repeat (6) tick();
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        lat_chk = 1'b1; acc_main = 1'b0; bp_arm = 1'b0; hold_left = 0;
        held_s = '0; held_c = '0;
        rst = 1'b1; in_valid_m = 1'b0; in_valid_s = 1'b0; out_ready_m = 1'b1;
        pp_all = '0;
        repeat (3) tick();

        // Reset state of every instance
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_valid_dut%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_sum_dut%0d", d), 32'(so[d]), 32'd0);
            chk($sformatf("rst_carry_dut%0d", d), 32'(co[d]), 32'd0);
`ifdef CSA_TREE_FINAL_ADD_EN
            chk($sformatf("rst_product_dut%0d", d), 32'(po[d]), 32'd0);
`endif
        end
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(ir[0]), 32'd1);

        // Basic sum: eight ones -> 8
        set_main(16'h0001);
        send_main();
        in_valid_m = 1'b0;
        drain();

        // Signed cancel: -1 + 1 -> 0
        set_main(16'h0000);
        pp_all[0 +: 16]  = 16'hFFFF;
        pp_all[16 +: 16] = 16'h0001;
        send_main();
        in_valid_m = 1'b0;
        drain();

        // Eight times -1 -> -8
        set_main(16'hFFFF);
        send_main();
        in_valid_m = 1'b0;
        drain();

        // Wrap-around: 8 * 0x4000 = 2^17 -> 0
        set_main(16'h4000);
        send_main();
        in_valid_m = 1'b0;
        drain();

        // Full-rate random stream
        for (int k = 0; k < 6; k++) begin
            set_main(16'h0000);
            for (int i = 0; i < 8; i++) pp_all[i*16 +: 16] = 16'($urandom_range(0, 65535));
            send_main();
        end
        in_valid_m = 1'b0;
        drain();

        // Backpressure: k = 1..6, three-cycle stall at the first result
        lat_chk = 1'b0;
        bp_arm  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            set_main(16'(k));
            send_main();
        end
        in_valid_m = 1'b0;
        drain();
        chk("bp_hold_seen", 32'(bp_arm), 32'd0);
        lat_chk = 1'b1;

        // Reset mid-flight: two sets in flight, reset also wins over a live input
        set_main(16'h0003);
        send_main();
        set_main(16'h0005);
        send_main();
        set_main(16'h0007);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid_m = 1'b0;
        chk("post_rst_valid", 32'(ov[0]), 32'd0);
        repeat (8) tick();
        set_main(16'h0009);
        send_main();
        in_valid_m = 1'b0;
        drain();

        // Parameter sweep: random sets into the 3/9/13 instances
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 13; i++) pp_all[i*16 +: 16] = 16'($urandom_range(0, 65535));
            in_valid_s = 1'b1;
            tick();
        end
        in_valid_s = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
